// File: rtl/burst_drain_pkg.sv
// Shared types for the burst drain: FSM state and the reason a held word
// is moved from the hold register into the output register.
package burst_drain_pkg;

    // Whether a burst is currently open.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OPEN = 1'b1
    } state_t;

    // Why the held word is released this cycle. REL_POP is the only cause
    // that does not close the burst.
    typedef enum logic [2:0] {
        REL_NONE    = 3'd0,
        REL_POP     = 3'd1,
        REL_FULL    = 3'd2,
        REL_TIMEOUT = 3'd3,
        REL_FLUSH   = 3'd4
    } rel_cause_t;

endpackage

// File: rtl/stream_reg.sv
// Single-entry valid/ready register carrying one word plus sop/eop framing.
// Handshake: a word moves when valid and ready are both high on a rising
// edge; while valid=1 and ready=0 the presented word and flags stay stable.
module stream_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sop,
    input  logic             in_eop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sop,
    output logic             out_eop
);

    // The slot can take a new word when empty or when its word leaves now.
    assign in_ready = !out_valid || out_ready;

    // Load a new word when the slot frees up; otherwise hold everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
                out_sop  <= in_sop;
                out_eop  <= in_eop;
            end
        end
    end

endmodule

// File: rtl/burst_drain.sv
// Drains a first-word-fall-through FIFO into sop/eop framed bursts of at
// most BURST_LEN words. A one-word hold register decides whether the held
// word ends the burst: full burst, idle timeout or flush close it; a
// following pop keeps it open.
module burst_drain
    import burst_drain_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int BURST_LEN = 16,
    parameter int TIMEOUT   = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_rd,
    input  logic             flush,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_sop,
    output logic             m_eop,
    output logic [15:0]      burst_cnt
);

    localparam int BW = $clog2(BURST_LEN);
    localparam int IW = $clog2(TIMEOUT);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

    state_t           state;
    rel_cause_t       rel_cause;
    logic [BW-1:0]    beat;
    logic [IW-1:0]    idle_cnt;
    logic             hold_valid;
    logic [WIDTH-1:0] hold_data;
    logic             hold_sop;
    logic             flush_pend;
    logic             rst_q;
    logic             out_free;
    logic             pop;
    logic             release_w;
    logic             rel_eop;
    logic             flush_hit;

    // A pop needs FIFO data, a hold slot that is free or being emptied, and
    // one settled cycle after reset.
    assign pop       = !fifo_empty && rst_q && (!hold_valid || out_free);
    assign fifo_rd   = pop;
    assign flush_hit = flush_pend || (flush && state == ST_OPEN);

    // Pick the release cause; closing causes take priority over a pop.
    always_comb begin
        rel_cause = REL_NONE;
        if (hold_valid && out_free) begin
            if (flush_hit)                rel_cause = REL_FLUSH;
            else if (idle_cnt == IDLE_LAST) rel_cause = REL_TIMEOUT;
            else if (beat == BEAT_LAST)   rel_cause = REL_FULL;
            else if (pop)                 rel_cause = REL_POP;
        end
    end

    assign release_w = (rel_cause != REL_NONE);
    assign rel_eop   = release_w && (rel_cause != REL_POP);

    // Allow pops only from the second cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_q <= 1'b0;
        else        rst_q <= 1'b1;
    end

    // Hold register: capture on pop; a word popped while the burst is idle
    // or just closing starts a new burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
            hold_sop   <= 1'b0;
        end else if (pop) begin
            hold_valid <= 1'b1;
            hold_data  <= fifo_dout;
            hold_sop   <= (state == ST_IDLE) || rel_eop;
        end else if (release_w) begin
            hold_valid <= 1'b0;
        end
    end

    // Burst FSM with beat position and latched flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            beat       <= '0;
            flush_pend <= 1'b0;
        end else begin
            if (release_w) begin
                if (rel_eop) begin
                    beat  <= '0;
                    state <= pop ? ST_OPEN : ST_IDLE;
                end else begin
                    beat <= beat + 1'b1;
                end
            end else if (pop && state == ST_IDLE) begin
                state <= ST_OPEN;
            end
            if (rel_eop)                        flush_pend <= 1'b0;
            else if (flush && state == ST_OPEN) flush_pend <= 1'b1;
        end
    end

    // Idle counter: cycles a word sits in hold without a pop, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  idle_cnt <= '0;
        else if (pop || release_w)                   idle_cnt <= '0;
        else if (hold_valid && idle_cnt != IDLE_LAST) idle_cnt <= idle_cnt + 1'b1;
    end

    // Completed-burst counter: one per accepted eop word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        burst_cnt <= '0;
        else if (m_valid && m_ready && m_eop) burst_cnt <= burst_cnt + 16'd1;
    end

    stream_reg #(.WIDTH(WIDTH)) u_out (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (release_w),
        .in_ready  (out_free),
        .in_data   (hold_data),
        .in_sop    (hold_sop),
        .in_eop    (rel_eop),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  (m_data),
        .out_sop   (m_sop),
        .out_eop   (m_eop)
    );

endmodule
